// File: rtl/rptr_empty_stream.sv
// Async FIFO read side: Gray/binary read pointers, empty/almost-empty/count status, AXI-Stream out.
// rq2_wptr change to tvalid is 3 cycles; a 2-entry skid buffer absorbs RAM latency so tready stalls never drop data.
module rptr_empty_stream #(
   parameter int ADDRSIZE      = 4,
   parameter int DSIZE         = 32,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   output logic [ADDRSIZE:0]   rptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic                ren,
   input  logic [DSIZE-1:0]    rdata,
   output logic [DSIZE-1:0]    m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   rcount
);
   localparam int PW = ADDRSIZE + 1;
   localparam logic [ADDRSIZE:0] AE_THRESH = PW'(AEMPTY_THRESH);

   function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
      logic [ADDRSIZE:0] b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] rbin_next;
   logic [ADDRSIZE:0] wbin_sync;
   logic [ADDRSIZE:0] rcount_next;
   logic              inflight;
   logic              pop;
   logic              push;
   logic [1:0]        bufcnt;
   logic [1:0]        bufcnt_next;
   logic [2:0]        occ_next;
   logic [DSIZE-1:0]  buf_head;
   logic [DSIZE-1:0]  buf_tail;

   assign m_axis_tvalid = (bufcnt != 2'd0);
   assign m_axis_tdata  = buf_head;
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign push          = inflight;

   // Occupancy the buffer will hold after this edge; a new read must still fit next cycle.
   assign occ_next    = {1'b0, bufcnt} + {2'b0, inflight} - {2'b0, pop};
   assign ren         = !rrst & !rempty & (occ_next < 3'd2);
   assign raddr       = rbin[ADDRSIZE-1:0];
   assign rbin_next   = rbin + {{ADDRSIZE{1'b0}}, ren};
   assign wbin_sync   = gray2bin(rq2_wptr);
   assign rcount_next = wbin_sync - rbin_next;
   assign bufcnt_next = bufcnt + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin     <= '0;
         rptr     <= '0;
         rempty   <= 1'b1;
         raempty  <= 1'b1;
         rcount   <= '0;
         inflight <= 1'b0;
         bufcnt   <= 2'd0;
         buf_head <= '0;
         buf_tail <= '0;
      end else begin
         rbin     <= rbin_next;
         rptr     <= bin2gray(rbin_next);
         rempty   <= (bin2gray(rbin_next) == rq2_wptr);
         rcount   <= rcount_next;
         raempty  <= (rcount_next <= AE_THRESH);
         inflight <= ren;
         bufcnt   <= bufcnt_next;
         // Head always carries the oldest word; tail only fills when head is held.
         case (bufcnt)
            2'd0: begin
               if (push) buf_head <= rdata;
            end
            2'd1: begin
               if (push && pop) buf_head <= rdata;
               else if (push)   buf_tail <= rdata;
            end
            default: begin
               if (pop) buf_head <= buf_tail;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rptr_empty_stream.sv
// Directed bench for rptr_empty_stream: vector table for reset/single word, sequences for burst, stall, wrap, reset.
`timescale 1ns/1ps
module tb_rptr_empty_stream;
   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic [4:0]  rq2_wptr = 5'd0;
   logic [4:0]  rptr;
   logic [3:0]  raddr;
   logic        ren;
   logic [31:0] rdata;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        rempty;
   logic        raempty;
   logic [4:0]  rcount;

   always #5 rclk = ~rclk;

   rptr_empty_stream #(.ADDRSIZE(4), .DSIZE(32), .AEMPTY_THRESH(2)) dut (
      .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
      .ren(ren), .rdata(rdata), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .rempty(rempty), .raempty(raempty), .rcount(rcount)
   );

   // RAM read port with 1-cycle latency
   logic [31:0] mem [0:15];
   always @(posedge rclk) if (ren) rdata <= mem[raddr];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   typedef struct {
      logic        rst;
      logic [4:0]  wptr;
      logic        rdy;
      logic        e_ren;
      logic [3:0]  e_raddr;
      logic        e_rempty;
      logic        e_raempty;
      logic [4:0]  e_rcount;
      logic [4:0]  e_rptr;
      logic        e_tvalid;
      logic        chk_data;
      logic [31:0] e_tdata;
   } vec_t;
   vec_t vt [10];

   logic [4:0]  wbin = 5'd0;
   logic [4:0]  issued = 5'd0;
   logic [4:0]  w_seen;
   logic [4:0]  exp_cnt;
   logic        model_on = 1'b0;
   logic [31:0] exp_q [$];
   int cyc = 0, n_ren = 0, npop = 0, first_pop = -1, last_pop = -1, total_pop = 0;

   task automatic step(input logic rdy, input logic rst);
      @(posedge rclk);
      w_seen = wbin;
      #1;
      m_axis_tready = rdy;
      rrst = rst;
      #1;
      cyc++;
      if (model_on) begin
         exp_cnt = w_seen - issued;
         chk("rcount", rcount, exp_cnt);
         chk("rempty", rempty, exp_cnt == 5'd0);
         chk("raempty", raempty, exp_cnt <= 5'd2);
         chk("rptr", rptr, gray(issued));
         chk("rcount_max", rcount <= 5'd16, 1'b1);
      end
      if (ren) begin
         if (model_on) chk("raddr", raddr, issued[3:0]);
         issued++;
         n_ren++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got %h expected no word", m_axis_tdata);
         end else begin
            chk("tdata_order", m_axis_tdata, exp_q.pop_front());
         end
         npop++;
         total_pop++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
   endtask

   task automatic write_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wbin[3:0]] = base + i;
         exp_q.push_back(base + i);
         wbin++;
      end
      rq2_wptr = gray(wbin);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (k < 100 && (exp_q.size() != 0 || m_axis_tvalid || !rempty)) begin
         step(1'b1, 1'b0);
         k++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      mem[0] = 32'hD000_0000;
      //           rst   wptr   rdy   ren   raddr rempt raemp rcount rptr  tvld  chkd  tdata
      vt[0] = '{1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0};
      vt[1] = '{1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0};
      vt[2] = '{1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0};
      vt[3] = '{1'b0, 5'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0};
      vt[4] = '{1'b0, 5'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 32'h0};
      vt[5] = '{1'b0, 5'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b0, 1'b1, 32'h0};
      vt[6] = '{1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 32'hD000_0000};
      vt[7] = '{1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 32'hD000_0000};
      vt[8] = '{1'b0, 5'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 32'hD000_0000};
      vt[9] = '{1'b0, 5'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd1, 1'b0, 1'b0, 32'h0};

      for (int i = 0; i < 10; i++) begin
         @(posedge rclk);
         #1;
         rrst = vt[i].rst;
         rq2_wptr = vt[i].wptr;
         m_axis_tready = vt[i].rdy;
         #1;
         chk($sformatf("v%0d_ren", i), ren, vt[i].e_ren);
         if (vt[i].e_ren) chk($sformatf("v%0d_raddr", i), raddr, vt[i].e_raddr);
         chk($sformatf("v%0d_rempty", i), rempty, vt[i].e_rempty);
         chk($sformatf("v%0d_raempty", i), raempty, vt[i].e_raempty);
         chk($sformatf("v%0d_rcount", i), rcount, vt[i].e_rcount);
         chk($sformatf("v%0d_rptr", i), rptr, vt[i].e_rptr);
         chk($sformatf("v%0d_tvalid", i), m_axis_tvalid, vt[i].e_tvalid);
         if (vt[i].chk_data) chk($sformatf("v%0d_tdata", i), m_axis_tdata, vt[i].e_tdata);
      end

      // restart from zero pointers for the full-depth burst
      wbin = 5'd0;
      rq2_wptr = 5'd0;
      issued = 5'd0;
      step(1'b1, 1'b1);
      chk("ren_in_reset", ren, 1'b0);
      step(1'b1, 1'b0);
      model_on = 1'b1;
      step(1'b1, 1'b0);

      n_ren = 0; npop = 0; first_pop = -1;
      write_words(16, 32'h1000_0000);
      chk("wptr_gray16", rq2_wptr, 5'b11000);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) step(1'b1, 1'b0);
      chk("burst_pops", npop, 16);
      chk("burst_gapless", last_pop - first_pop, 15);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("burst_reads", n_ren, 16);
      chk("burst_rptr", rptr, 5'b11000);
      chk("burst_rempty", rempty, 1'b1);

      n_ren = 0;
      write_words(8, 32'h2000_0000);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0);
         if (m_axis_tvalid) chk("stall_tdata", m_axis_tdata, 32'h2000_0000);
      end
      chk("stall_reads", n_ren, 2);
      chk("stall_rcount", rcount, 5'd6);
      chk("stall_tvalid", m_axis_tvalid, 1'b1);
      npop = 0; first_pop = -1;
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) step(1'b1, 1'b0);
      chk("release_pops", npop, 8);
      chk("release_gapless", last_pop - first_pop, 7);
      drain();

      total_pop = 0;
      write_words(16, 32'h3000_0000);
      drain();
      write_words(16, 32'h3100_0000);
      drain();
      write_words(8, 32'h3200_0000);
      drain();
      chk("wrap_pops", total_pop, 40);
      chk("wrap_rptr", rptr, 5'd0);
      chk("wrap_rcount", rcount, 5'd0);

      // one word buffered and one in flight, then a single reset cycle
      model_on = 1'b0;
      write_words(4, 32'h4000_0000);
      step(1'b0, 1'b0);
      chk("rst_seq_ren1", ren, 1'b1);
      step(1'b0, 1'b0);
      chk("rst_seq_ren2", ren, 1'b1);
      step(1'b1, 1'b1);
      chk("rst_seq_ren_in_reset", ren, 1'b0);
      exp_q.delete();
      wbin = 5'd0;
      rq2_wptr = 5'd0;
      step(1'b1, 1'b0);
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_tdata", m_axis_tdata, 32'h0);
      chk("rst_rempty", rempty, 1'b1);
      chk("rst_raempty", raempty, 1'b1);
      chk("rst_rcount", rcount, 5'd0);
      chk("rst_rptr", rptr, 5'd0);
      chk("rst_ren", ren, 1'b0);
      step(1'b1, 1'b0);
      chk("post_rst_tvalid", m_axis_tvalid, 1'b0);
      chk("post_rst_tdata", m_axis_tdata, 32'h0);
      chk("post_rst_ren", ren, 1'b0);
      step(1'b1, 1'b0);
      chk("idle_tvalid", m_axis_tvalid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rptr_empty_stream.md
# rptr_empty_stream

Read-side controller of the async FIFO, sitting directly downstream of the write-to-read pointer synchronizer. It consumes the two-flop-synchronized Gray write pointer `rq2_wptr`, owns the binary/Gray read pointers, and drives the dual-port RAM read port. It produces empty, almost-empty and fill-count status and presents data as an AXI-Stream master through a 2-entry output buffer, hiding the RAM's 1-cycle read latency.

## Interface
Parameters:
- `ADDRSIZE`, 4: RAM address width; depth 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `DSIZE`, 32: data width.
- `AEMPTY_THRESH`, 2: `raempty` asserts when `rcount` <= this value.

Ports:
- `rclk` in 1: the only clock. One clock; reset is synchronous and active-high.
- `rrst` in 1: synchronous, active-high reset.
- `rq2_wptr` in ADDRSIZE+1: Gray write pointer, already synchronized to `rclk`.
- `rptr` out ADDRSIZE+1: registered Gray read pointer, to the read-to-write synchronizer.
- `raddr` out ADDRSIZE: RAM read address, `rbin[ADDRSIZE-1:0]`.
- `ren` out 1: RAM read enable; `rdata` is valid the cycle after `ren`.
- `rdata` in DSIZE: RAM read data.
- `m_axis_tdata` out DSIZE: head of the output buffer.
- `m_axis_tvalid` out 1: output buffer is non-empty.
- `m_axis_tready` in 1: downstream accept.
- `rempty` out 1: registered; RAM holds no unread word.
- `raempty` out 1: registered almost-empty flag.
- `rcount` out ADDRSIZE+1: registered count of words in the RAM not yet issued.

## Operation
- State: `rbin` and `rptr` (ADDRSIZE+1 bits), `rempty`, `raempty`, `rcount`, `inflight` (1 bit), and the 2-entry output buffer with `bufcnt` in 0..2.
- `pop = m_axis_tvalid & m_axis_tready`.
- `ren = !rrst & !rempty & (bufcnt + inflight - pop < 2)`. This is combinational from registered state and `m_axis_tready`.
- On `ren`: `rbin <= rbin+1`, wrapping modulo 2^(ADDRSIZE+1). `rptr <= bin2gray(rbin+ren)`.
- `rempty <= (bin2gray(rbin+ren) == rq2_wptr)`.
- `inflight <= ren`. When `inflight` is set, `rdata` is written to the buffer tail that cycle.
- Buffer push and pop in the same cycle is legal; `bufcnt` is then unchanged.
- `m_axis_tvalid = (bufcnt != 0)`; it never depends on `m_axis_tready`.
- `m_axis_tdata` holds stable while `tvalid & !tready`.
- `rcount <= gray2bin(rq2_wptr) - (rbin+ren)`, modulo 2^(ADDRSIZE+1).
- `raempty <= (that value <= AEMPTY_THRESH)`.
- Buffer order is strict FIFO: words leave in RAM address order.

## Timing
- Reset values: `rbin`=0, `rptr`=0, `rempty`=1, `raempty`=1, `rcount`=0, `inflight`=0, `bufcnt`=0, `m_axis_tvalid`=0, `ren`=0, `m_axis_tdata`=0.
- Reset asserted mid-operation: every item above clears at the next edge. Any in-flight `rdata` is discarded. `ren` is 0 during every reset cycle.
- Latency, non-empty path: `rq2_wptr` changes in cycle t.
  - `rempty` falls in t+1; `ren`=1 in t+1.
  - `rdata` arrives in t+2.
  - `m_axis_tvalid`=1 in t+3.
- Throughput: with `m_axis_tready` held high and the RAM non-empty, one word per cycle sustained.
- Backpressure: at most 2 buffered words plus 0 in flight when stalled. `ren` stops the cycle `bufcnt + inflight` reaches 2. No word is ever dropped or overwritten.
- Empty boundary: the read that consumes the last word sets `rempty` at the same edge. The next cycle has `ren`=0; the pointer never passes `rq2_wptr`.
- Wrap: `rbin` 2^(ADDRSIZE+1)-1 -> 0. The Gray MSB toggles, so full and empty remain distinguishable. `rcount` arithmetic is modulo.
- Simultaneous `rq2_wptr` advance and a last-word read: `rempty` evaluates against the new `rq2_wptr` and stays 0.

## Test plan
- After reset, `rq2_wptr` stays 0 -> `rempty`=1, `raempty`=1, `rcount`=0, `m_axis_tvalid`=0, `ren` never 1.
- Write 1 word (`rq2_wptr`: 0 -> 1) with tready=1 -> `ren` pulses once at `raddr`=0. `tvalid` goes high 3 cycles after the pointer change, carries RAM[0], and `rptr`=1. `rempty` returns to 1 one cycle after `ren`.
- ADDRSIZE=4, 16 words written (`rq2_wptr`=gray(16)=5'b11000), tready=1 -> 16 words in order, one per cycle. `rcount` falls 16 -> 0, `raempty` asserts at `rcount`=2, final `rptr`=5'b11000.
- 8 words written, tready=0 -> exactly 2 reads issued, `rcount`=6, `tdata` stable. Release tready -> the remaining 6 words stream without gaps, in order.
- Run 40 words through in 16-word bursts -> pointer wraps 31 -> 0 and data order is preserved. `rcount` never exceeds 16.
- Assert `rrst` for 1 cycle with 1 word buffered and 1 in flight -> all outputs return to reset values the next cycle. No stale `rdata` appears on `m_axis_tdata`.
